fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage placed directly upstream of the decode/execute datapath. It owns the program counter, issues addresses to a synchronous-read instruction ROM, and buffers returned words in a 2-entry prefetch queue. It presents instructions to the downstream stage over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and squash in-flight reads.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; low 2 bits must be 0.
- `QDEPTH`, default 2: prefetch queue entries; legal values 2 to 8.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_en`  out  1: read request this cycle.
- `imem_addr`  out  32: word-aligned read address.
- `imem_rdata`  in  32: ROM data; valid the cycle after an `imem_en` request.
- `redirect_valid`  in  1: taken branch or jump resolved; load a new PC.
- `redirect_pc`  in  32: new fetch address; bits [1:0] ignored and treated as 0.
- `if_valid`  out  1: `if_instr`/`if_pc` hold a valid instruction.
- `id_ready`  in  1: downstream accepts the word this cycle.
- `if_instr`  out  32: instruction word.
- `if_pc`  out  32: address of `if_instr`.
- `if_pc_plus4`  out  32: `if_pc + 4`, mod 2^32; used as the link value.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `inflight`: 1 bit.
  - `inflight_pc`: PC of the outstanding read.
  - Queue: circular; head/tail pointers plus a count from 0 to QDEPTH; each entry holds {instr, pc}.
- Pop: `if_valid && id_ready`.
- Issue condition: `!rst && !redirect_valid && (count + inflight - pop) < QDEPTH`.
- On issue:
  - `imem_en=1`, `imem_addr=fetch_pc`.
  - `fetch_pc += 4`, wrapping 32'hFFFF_FFFC to 0.
  - `inflight<=1`, `inflight_pc<=fetch_pc`.
  - If not issuing, `inflight<=0`.
- Response: when `inflight==1`, `{imem_rdata, inflight_pc}` is pushed the same cycle. The push is guaranteed to fit because of the issue credit rule.
- Simultaneous push and pop: count unchanged.
  - Pop when count==0 is only possible under bypass.
- Redirect (highest priority, overrides issue, push and pop):
  - Queue count goes to 0.
  - Any in-flight response is discarded: `inflight<=0`, and data arriving next cycle is not pushed.
  - `fetch_pc<={redirect_pc[31:2],2'b00}`.
  - `if_valid=0` in the redirect cycle.
  - First request to the new PC is issued the following cycle.
- `if_valid` is 0 whenever count==0, except in the bypass case described under Configuration.
- Reset: queue emptied, `inflight=0`, `fetch_pc=RESET_PC`.
  - Reset mid-operation discards all queued and in-flight words identically.
- Stall (`id_ready=0`): queue fills to QDEPTH, then issue halts.
  - `if_instr`/`if_pc` stay stable while `if_valid && !id_ready`.

## Timing
- Reset values:
  - `imem_en=0`, `imem_addr=RESET_PC`.
  - `if_valid=0`, `if_instr=0`, `if_pc=0`, `if_pc_plus4=4`.
- Cycle 0 is the first cycle with `rst=0`:
  - First request at cycle 0 (`imem_addr=RESET_PC`).
  - Data returns at cycle 1.
- Fetch-to-valid latency: 1 cycle with bypass, 2 cycles without.
- Steady-state throughput: 1 instruction/cycle when `id_ready=1`, either configuration.
- Redirect asserted in cycle R:
  - Request to `redirect_pc` in cycle R+1.
  - `if_valid` for it at R+2 with bypass, R+3 without.
- Outputs come from registered queue state, except in the bypass path. There is no combinational path from `id_ready` to `imem_addr`; `imem_en` depends on `id_ready` through the credit rule.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When count==0 and an un-squashed response arrives, the response drives `if_valid=1`, `if_instr=imem_rdata`, `if_pc=inflight_pc` combinationally.
  - If `id_ready=1`, it is consumed without a push; otherwise it is pushed.
- `FETCH_BYPASS_EN` undefined:
  - Responses always enter the queue first.
  - `if_*` outputs come only from the queue head.
  - One extra cycle of latency after reset and after each redirect.

## Test plan
- Reset release with RESET_PC=0 and `id_ready=1` held: `if_pc` sequence 0,4,8,C on consecutive cycles. First valid at cycle 1 with bypass, cycle 2 without.
- Hold `id_ready=0` from cycle 0:
  - Exactly QDEPTH requests issued, then `imem_en=0`.
  - `if_pc` stays 0.
  - Release `id_ready`: 0,4 pop back-to-back with no dropped or duplicated PC.
- Redirect to 32'h0000_0103 while a read is in flight and the queue is full:
  - The next `if_valid` word has `if_pc=0x100`.
  - No stale word appears.
- Redirect and `id_ready` in the same cycle with count=1: head is not consumed, `if_valid=0` that cycle.
- Redirect to 32'hFFFF_FFF8: `if_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. `if_pc_plus4` for FFFF_FFFC is 0.
- Assert `rst` for one cycle mid-stream with the queue full:
  - Next cycle `if_valid=0`.
  - Fetch restarts at RESET_PC.
  - The ROM response from the pre-reset request is discarded.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : Instruction fetch stage: PC, synchronous ROM requests and  |
// |               a QDEPTH-entry prefetch queue with valid/ready output.     |
// |               Define FETCH_BYPASS_EN to forward ROM data straight to the |
// |               outputs when the queue is empty.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int                 c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(QDEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(QDEPTH - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(QDEPTH);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_inflight_pc;
    logic               r_inflight;
    logic [31:0]        r_q_instr [QDEPTH];
    logic [31:0]        r_q_pc    [QDEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_bypass;
    logic               w_pop;
    logic               w_q_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_CNT_W:0]   w_credit;
    logic [31:0]        w_redirect_aligned;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty            = (r_count == '0);
    assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty && r_inflight;
`else
    assign w_bypass = 1'b0;
`endif

    assign if_valid    = !rst && !redirect_valid && (!w_empty || w_bypass);
    assign if_instr    = w_bypass ? imem_rdata    : r_q_instr[r_head];
    assign if_pc       = w_bypass ? r_inflight_pc : r_q_pc[r_head];
    assign if_pc_plus4 = if_pc + 32'd4;

    assign w_pop   = if_valid && id_ready;
    assign w_q_pop = w_pop && !w_empty;
    // A bypassed word that is accepted immediately never occupies a slot.
    assign w_push  = r_inflight && !redirect_valid && !(w_bypass && id_ready);

    // Outstanding read counts against capacity so its response always fits.
    assign w_credit  = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight) - (c_CNT_W + 1)'(w_pop);
    assign w_issue   = !rst && !redirect_valid && (w_credit < c_DEPTH);
    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_aligned;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_q_instr[r_tail] <= imem_rdata;
                r_q_pc[r_tail]    <= r_inflight_pc;
                r_tail            <= f_next(r_tail);
            end
            if (w_q_pop) begin
                r_head <= f_next(r_head);
            end
            case ({w_push, w_q_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
